// File: rtl/axis_rr_pkt_arbiter_pkg.sv
// Shared types and the round-robin search used by the packet arbiter.
package axis_rr_pkt_arbiter_pkg;

  localparam int unsigned C_MAX_PORTS = 16;
  localparam int unsigned C_IDX_W     = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // First set bit of req strictly after 'last', wrapping over n ports; returns 'last' if req is empty.
  function automatic logic [C_IDX_W-1:0] rr_next(input logic [C_MAX_PORTS-1:0] req,
                                                 input logic [C_IDX_W-1:0]     last,
                                                 input int unsigned            n);
    logic [C_IDX_W-1:0] pick;
    logic               found;
    logic [C_IDX_W:0]   idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= C_MAX_PORTS; i++) begin
      idx = (C_IDX_W+1)'(last) + (C_IDX_W+1)'(i);
      if (idx >= (C_IDX_W+1)'(n)) begin
        idx = idx - (C_IDX_W+1)'(n);
      end
      if (!found && (i <= n) && req[idx[C_IDX_W-1:0]]) begin
        pick  = idx[C_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_if.sv
// AXI-Stream bundle of the arbiter: N packed input streams plus the merged, port-tagged output.
interface axis_rr_pkt_arbiter_if #(
  parameter int unsigned C_NUM_PORTS   = 4,
  parameter int unsigned C_WIDTH_TDATA = 512,
  parameter int unsigned C_WIDTH_TKEEP = C_WIDTH_TDATA / 8,
  parameter int unsigned C_WIDTH_ID    = $clog2(C_NUM_PORTS)
);

  logic [C_NUM_PORTS-1:0]               in_TVALID;
  logic [C_NUM_PORTS-1:0]               in_TREADY;
  logic [C_NUM_PORTS*C_WIDTH_TDATA-1:0] in_TDATA;
  logic [C_NUM_PORTS*C_WIDTH_TKEEP-1:0] in_TKEEP;
  logic [C_NUM_PORTS-1:0]               in_TLAST;

  logic                                 out_TVALID;
  logic                                 out_TREADY;
  logic [C_WIDTH_TDATA-1:0]             out_TDATA;
  logic [C_WIDTH_TKEEP-1:0]             out_TKEEP;
  logic                                 out_TLAST;
  logic [C_WIDTH_ID-1:0]                out_TID;

  // Traffic side: sources on the inputs, sink on the merged output.
  modport master (
    output in_TVALID, in_TDATA, in_TKEEP, in_TLAST, out_TREADY,
    input  in_TREADY, out_TVALID, out_TDATA, out_TKEEP, out_TLAST, out_TID
  );

  // Arbiter side.
  modport slave (
    input  in_TVALID, in_TDATA, in_TKEEP, in_TLAST, out_TREADY,
    output in_TREADY, out_TVALID, out_TDATA, out_TKEEP, out_TLAST, out_TID
  );

endinterface

// File: rtl/axis_rr_pkt_arbiter_reg_slice.sv
// Two-entry registered skid slice: output fully registered, ready depends only on local state.
module axis_reg_slice #(
  parameter int unsigned C_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH-1:0] out_data
);

  logic               skid_valid;
  logic [C_WIDTH-1:0] skid_data;
  logic               in_fire;
  logic               out_free;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Fill the output register first; park a beat in the skid entry only while the output stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (in_fire) begin
      if (out_free) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (out_free) begin
      out_valid  <= skid_valid;
      skid_valid <= 1'b0;
      if (skid_valid) begin
        out_data <= skid_data;
      end
    end
  end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin merge of N AXI-Stream inputs; grant is locked from first beat to TLAST.
module axis_rr_pkt_arbiter
  import axis_rr_pkt_arbiter_pkg::*;
#(
  parameter int unsigned C_NUM_PORTS   = 4,
  parameter int unsigned C_WIDTH_TDATA = 512,
  parameter int unsigned C_WIDTH_TKEEP = C_WIDTH_TDATA / 8,
  parameter int unsigned C_WIDTH_ID    = $clog2(C_NUM_PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [C_NUM_PORTS-1:0] cfg_port_en,
  axis_rr_pkt_arbiter_if.slave   bus,
  output logic                   busy
);

  localparam int unsigned C_WIDTH_SLICE = C_WIDTH_TDATA + C_WIDTH_TKEEP + 1 + C_WIDTH_ID;

  state_t                   state;
  state_t                   state_nxt;
  logic [C_WIDTH_ID-1:0]    grant;
  logic [C_WIDTH_ID-1:0]    grant_nxt;
  logic [C_WIDTH_ID-1:0]    last_grant;
  logic [C_WIDTH_ID-1:0]    last_grant_nxt;
  logic [C_NUM_PORTS-1:0]   req;
  logic [C_NUM_PORTS-1:0]   req_other;
  logic                     slice_in_valid;
  logic                     slice_in_ready;
  logic                     accept_last;
  logic [C_WIDTH_SLICE-1:0] slice_in_data;
  logic [C_WIDTH_SLICE-1:0] slice_out_data;

  assign req         = bus.in_TVALID & cfg_port_en;
  assign req_other   = req & ~(C_NUM_PORTS'(1) << grant);
  assign accept_last = slice_in_valid && slice_in_ready && bus.in_TLAST[grant];
  assign busy        = (state == S_BUSY);

  // State, current grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= C_WIDTH_ID'(C_NUM_PORTS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Arbitrate from idle, or re-arbitrate in the TLAST cycle so back-to-back packets have no bubble.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_nxt = S_BUSY;
          grant_nxt = C_WIDTH_ID'(rr_next(C_MAX_PORTS'(req), C_IDX_W'(last_grant), C_NUM_PORTS));
        end
      end
      S_BUSY: begin
        if (accept_last) begin
          last_grant_nxt = grant;
          if (|req_other) begin
            grant_nxt = C_WIDTH_ID'(rr_next(C_MAX_PORTS'(req_other), C_IDX_W'(grant), C_NUM_PORTS));
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ready only toward the locked port; mux its beat and tag it with the grant.
  always_comb begin
    bus.in_TREADY  = '0;
    slice_in_valid = 1'b0;
    if (state == S_BUSY) begin
      bus.in_TREADY[grant] = slice_in_ready;
      slice_in_valid       = bus.in_TVALID[grant];
    end
    slice_in_data = {bus.in_TDATA[32'(grant) * C_WIDTH_TDATA +: C_WIDTH_TDATA],
                     bus.in_TKEEP[32'(grant) * C_WIDTH_TKEEP +: C_WIDTH_TKEEP],
                     bus.in_TLAST[grant],
                     grant};
  end

  axis_reg_slice #(
    .C_WIDTH (C_WIDTH_SLICE)
  ) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (slice_in_valid),
    .in_ready  (slice_in_ready),
    .in_data   (slice_in_data),
    .out_valid (bus.out_TVALID),
    .out_ready (bus.out_TREADY),
    .out_data  (slice_out_data)
  );

  assign {bus.out_TDATA, bus.out_TKEEP, bus.out_TLAST, bus.out_TID} = slice_out_data;

endmodule
